// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// A hit returns the instruction combinationally; a miss stalls fetch and refills the whole line.
module icache_dm #(
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pcF,
    input  logic        inv,
    output logic [31:0] instrF,
    output logic        stallF,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int WB      = $clog2(WORDS_PER_LINE);
    localparam int IB      = $clog2(LINES);
    localparam int LINE_LO = 2 + WB;
    localparam int TAG_LO  = LINE_LO + IB;
    localparam int TW      = 32 - TAG_LO;
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0]     valid;
    logic [TW-1:0]        tag_array  [LINES];
    logic [31:0]          data_array [LINES][WORDS_PER_LINE];
    logic [31-LINE_LO:0]  refill_line;
    logic [WB-1:0]        count;
    logic                 inv_pending;

    logic [WB-1:0] word;
    logic [IB-1:0] index;
    logic [TW-1:0] tag;
    logic [IB-1:0] refill_index;
    logic [TW-1:0] refill_tag;
    logic          hit;
    logic          start_refill;
    logic          accept;
    logic          last_word;
    logic          unused_offset;

    assign word          = pcF[2 +: WB];
    assign index         = pcF[LINE_LO +: IB];
    assign tag           = pcF[31:TAG_LO];
    assign refill_index  = refill_line[IB-1:0];
    assign refill_tag    = refill_line[31-LINE_LO:IB];
    assign unused_offset = &{1'b0, pcF[1:0]};

    // Lookups only ever hit while idle, so a line being refilled never appears valid early.
    assign hit = (state == IDLE) && valid[index] && (tag_array[index] == tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        start_refill = 1'b0;
        accept       = 1'b0;
        last_word    = 1'b0;
        stallF       = ~hit;
        instrF       = hit ? data_array[index][word] : NOP_INSTR;
        case (state)
            IDLE: begin
                if (!hit) begin
                    start_refill = 1'b1;
                    state_next   = REFILL;
                end
            end
            REFILL: begin
                if (mem_req && mem_rvalid) begin
                    accept = 1'b1;
                    if (count == LAST_WORD) begin
                        last_word  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An invalidate seen during a refill is remembered and applied when the line completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            refill_line <= '0;
            count       <= '0;
            inv_pending <= 1'b0;
        end else begin
            if (state == IDLE && inv) begin
                valid <= '0;
            end
            if (state == REFILL && inv) begin
                inv_pending <= 1'b1;
            end
            if (start_refill) begin
                refill_line <= pcF[31:LINE_LO];
                mem_addr    <= {pcF[31:LINE_LO], {LINE_LO{1'b0}}};
                mem_req     <= 1'b1;
                count       <= '0;
                inv_pending <= 1'b0;
            end
            if (accept) begin
                count    <= count + WB'(1);
                mem_addr <= mem_addr + 32'd4;
                if (last_word) begin
                    mem_req     <= 1'b0;
                    inv_pending <= 1'b0;
                    if (inv_pending || inv) begin
                        valid <= '0;
                    end else begin
                        valid[refill_index] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_array[refill_index][count] <= mem_rdata;
        end
        if (last_word) begin
            tag_array[refill_index] <= refill_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed fetch scenarios followed by random fetch/invalidate traffic,
// all compared against a line-level model of the cache and a fixed instruction memory.
module tb_icache_dm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pcF = '0;
    logic        inv = 1'b0;
    logic [31:0] instrF;
    logic        stallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;
    bit run_checks = 1'b0;
    bit rand_lat = 1'b0;
    bit force_stray = 1'b0;
    int lat = 2;

    bit          m_valid [16];
    int unsigned m_tag [16];
    bit          m_busy = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_base = '0;
    int          m_cnt = 0;
    logic [31:0] addr_log [$];

    icache_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcF        (pcF),
        .inv        (inv),
        .instrF     (instrF),
        .stallF     (stallF),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 16) % 16);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return int'(a / 256);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return !m_busy && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step();
        while (m_busy && n < budget) begin
            step();
            n++;
        end
        if (m_busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL refill timeout: still busy after %0d cycles", budget);
        end
    endtask

    task automatic check_log(input string name, input logic [31:0] base);
        check({name, " count"}, 32'(addr_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < addr_log.size()) check(name, addr_log[k], base + 32'(4 * k));
        end
    endtask

    // Line-level model: a line becomes usable only once all four words have arrived.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                m_busy = 1'b0;
                m_pend = 1'b0;
                m_cnt  = 0;
                m_base = '0;
            end else if (!m_busy) begin
                bit h;
                h = model_hit(pcF);
                if (inv) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                if (!h) begin
                    m_busy = 1'b1;
                    m_base = pcF & ~32'hF;
                    m_cnt  = 0;
                    m_pend = 1'b0;
                end
            end else begin
                if (inv) m_pend = 1'b1;
                if (mem_rvalid) begin
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_busy = 1'b0;
                        if (m_pend) begin
                            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                        end else begin
                            m_valid[idx_of(m_base)] = 1'b1;
                            m_tag[idx_of(m_base)]   = tag_of(m_base);
                        end
                        m_pend = 1'b0;
                    end
                end
            end
        end
    end

    // Backing memory: answers the word the model expects, plus occasional stray strobes while idle.
    initial begin
        int wc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_rvalid = 1'b0;
                wc = 0;
            end else if (mem_rvalid) begin
                mem_rvalid = 1'b0;
                wc = 0;
            end else if (m_busy) begin
                wc++;
                if (wc >= lat) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(m_base + 32'(4 * m_cnt));
                    addr_log.push_back(mem_addr);
                    if (rand_lat) lat = $urandom_range(1, 4);
                end
            end else if (force_stray || (rand_lat && $urandom_range(0, 19) == 0)) begin
                force_stray = 1'b0;
                mem_rvalid  = 1'b1;
                mem_rdata   = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && run_checks) begin
                bit exp_hit;
                exp_hit = model_hit(pcF);
                check("stallF", 32'(stallF), 32'(!exp_hit));
                check("instrF", instrF, exp_hit ? mem_word(pcF & ~32'h3) : NOP);
                check("mem_req", 32'(mem_req), 32'(m_busy));
                if (m_busy) check("mem_addr", mem_addr, m_base + 32'(4 * m_cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pcF   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset stallF", 32'(stallF), 32'd1);
        check("reset instrF", instrF, NOP);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        run_checks = 1'b1;

        addr_log.delete();
        wait_idle(100);
        check_log("fill0 addr", 32'h0);
        for (int w = 0; w < 4; w++) begin
            pcF = 32'(4 * w);
            @(negedge clk);
            check("hit0 instr", instrF, 32'h100 + 32'(4 * w));
            check("hit0 stall", 32'(stallF), 32'd0);
            step();
        end

        pcF = 32'h104;
        addr_log.delete();
        wait_idle(100);
        check_log("conflict addr", 32'h100);
        @(negedge clk);
        check("conflict hit instr", instrF, 32'h204);
        check("conflict hit stall", 32'(stallF), 32'd0);
        step();
        pcF = 32'h0;
        @(negedge clk);
        check("evicted stall", 32'(stallF), 32'd1);
        wait_idle(100);

        pcF = 32'h40;
        addr_log.delete();
        step();
        pcF = 32'h80;
        wait_idle(100);
        check_log("redirect addr", 32'h40);
        @(negedge clk);
        check("redirect miss stall", 32'(stallF), 32'd1);
        @(negedge clk);
        check("redirect new req", 32'(mem_req), 32'd1);
        check("redirect new addr", mem_addr, 32'h80);
        step();
        wait_idle(100);

        pcF = 32'h20;
        wait_idle(100);
        inv = 1'b1;
        @(negedge clk);
        check("inv same-cycle hit", 32'(stallF), 32'd0);
        step();
        inv = 1'b0;
        @(negedge clk);
        check("inv then miss", 32'(stallF), 32'd1);
        step();
        wait_idle(100);

        pcF = 32'h30;
        addr_log.delete();
        step();
        inv = 1'b1;
        step();
        inv = 1'b0;
        wait_idle(100);
        check_log("inv refill addr", 32'h30);
        @(negedge clk);
        check("inv refill not valid", 32'(stallF), 32'd1);
        step();
        wait_idle(100);

        pcF = 32'h50;
        begin
            int n = 0;
            while (!(m_busy && m_cnt == 2) && n < 50) begin
                step();
                n++;
            end
            if (!(m_busy && m_cnt == 2)) begin
                checks++;
                failures++;
                $display("[TB] FAIL mid-refill wait: second word never returned");
            end
        end
        rst_n = 1'b0;
        #1;
        check("midreset mem_req", 32'(mem_req), 32'd0);
        check("midreset mem_addr", mem_addr, 32'd0);
        check("midreset stallF", 32'(stallF), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        force_stray = 1'b1;
        @(negedge clk);
        check("post-reset miss", 32'(stallF), 32'd1);
        step();
        wait_idle(100);

        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [31:0] t;
                t = ($urandom_range(0, 3) == 3) ? 32'h00FF_FFFF : 32'($urandom_range(0, 2));
                pcF = (t << 8) | (32'($urandom_range(0, 15)) << 4) |
                      (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            end
            inv = ($urandom_range(0, 39) == 0);
            step();
        end
        inv = 1'b0;
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache that answers fetch-stage PC requests and returns instrF.
- Hits return the instruction combinationally in the same cycle, so the fetch pipeline register captures it at the next clk edge.
- Misses raise stallF and refill the whole line from a backing memory over a simple req/rvalid bus.
- Sits between the fetch stage (pcF in, instrF out) and the instruction memory.

Parameters:
- LINES, 16, number of cache lines; power of two, >=2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2.
- NOP_INSTR, 32'h00000013, value driven on instrF whenever stallF=1.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- pcF  input  32  fetch address from fetch stage
- inv  input  1  invalidate all lines (fence.i)
- instrF  output  32  instruction for pcF
- stallF  output  1  high = instrF not valid; fetch must hold pcF and not advance
- mem_req  output  1  backing-memory word request, level
- mem_addr  output  32  word address of the current request, byte address, [1:0]=0
- mem_rvalid  input  1  one-cycle strobe, mem_rdata valid
- mem_rdata  input  32  returned word

Behaviour:
- Reset/clock: rst_n asynchronous, active-low; clock clk.
- Reset values: all valid bits 0, state IDLE, mem_req=0, mem_addr=0, inv_pending=0, refill counter=0. With no valid lines, stallF=1 and instrF=NOP_INSTR after reset.
- Address split (defaults):
  - offset = pcF[1:0], ignored.
  - word = pcF[3:2], width log2(WORDS_PER_LINE).
  - index = pcF[7:4], width log2(LINES).
  - tag = the remaining upper bits, pcF[31:8].
- Storage: data array LINES x WORDS_PER_LINE x 32, tag array, valid bits. All in flops with combinational read.
- hit = valid[index] && tag_array[index]==tag && state==IDLE.
- IDLE with hit:
  - instrF = data[index][word]; stallF=0; no memory traffic.
- IDLE with miss:
  - stallF=1; instrF=NOP_INSTR.
  - Next edge: latch line base (pcF with word and offset bits zeroed) into refill_addr; counter=0; go REFILL.
  - Next edge also drives mem_req=1 and mem_addr=refill_addr.
- REFILL:
  - stallF=1, instrF=NOP_INSTR throughout.
  - mem_req stays high while waiting for word k; mem_addr = refill_addr + 4*k.
  - On a mem_rvalid edge: write mem_rdata into data[refill_index][k] and increment k.
  - If k was WORDS_PER_LINE-1: write tag, set valid (unless inv_pending), drop mem_req, go IDLE.
  - mem_rvalid is ignored whenever mem_req=0.
- Refill address is latched. pcF changes during REFILL, such as a branch redirect, do not alter the refill. After return to IDLE, lookup uses the current pcF, and a new miss starts another refill.
- Miss-to-hit latency: 1 + sum of memory latencies per word. Hit is visible the cycle after the final mem_rvalid.
- inv:
  - In IDLE: all valid bits clear on the next edge. The lookup in the same cycle still uses the pre-clear state.
  - In REFILL: sets inv_pending. At refill completion all valid bits clear, the refilled line is not validated, and inv_pending clears.
  - inv asserted on the final-word cycle also counts as pending.
- Reset mid-refill: returns immediately to reset values; any in-flight memory response is ignored because mem_req=0.
- No partial-line hits: a line is valid only after all words are written.
- Conflict: two PCs with the same index and different tags evict each other; no write-back is needed (read-only).

Test Plan:
- Reset, pcF=0x00000000, memory returns mem_rdata=0x100+4k after 2-cycle latency per word:
  - mem_addr steps 0x0,0x4,0x8,0xC; stallF=1 and instrF=0x00000013 during refill.
  - Then pcF=0x0/0x4/0x8/0xC hit, returning 0x100/0x104/0x108/0x10C with stallF=0.
- After the line 0x00 fill, pcF=0x00000104 (same index 0, tag 1):
  - Miss, refill from 0x100.
  - Then pcF=0x00000000 misses again (eviction).
- During REFILL of 0x40, pcF jumps to 0x80:
  - Refill still fetches 0x40..0x4C.
  - Then miss on 0x80 starts refill at mem_addr=0x80.
- Line 0x20 valid; pulse inv for one cycle in IDLE:
  - pcF=0x20 on the following cycle misses, stallF=1.
- inv pulsed mid-refill of 0x30:
  - Refill completes (4 requests).
  - pcF=0x30 misses again immediately.
- rst_n low after the 2nd returned word of a refill:
  - mem_req=0 and mem_addr=0 immediately.
  - A late mem_rvalid is ignored.
  - pcF=that line misses after reset.
